// File: rtl/ysyx_25030085_idu_if.sv
// ============================================================================
// ysyx_25030085_idu_if
// Handshake and decoded-bundle bus between IFU, IDU and EXU.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ysyx_25030085_idu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic            mem_wen;
  logic            mem_ren;
  logic [1:0]      mem_size;
  logic            mem_uns;
  logic [1:0]      wb_sel;
  logic            reg_wen;
  logic            branch;
  logic [2:0]      br_func;
  logic [1:0]      jump;
  logic            alu_src;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] out_pc;
  logic            ebreak;
  logic            illegal;

  // master is the decoder itself; slave is the IFU/EXU environment
  modport master (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, mem_wen, mem_ren, mem_size, mem_uns, wb_sel,
           reg_wen, branch, br_func, jump, alu_src, alu_op, imm, rs1, rs2, rd,
           out_pc, ebreak, illegal
  );

  modport slave (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, mem_wen, mem_ren, mem_size, mem_uns, wb_sel,
           reg_wen, branch, br_func, jump, alu_src, alu_op, imm, rs1, rs2, rd,
           out_pc, ebreak, illegal
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_25030085_idu.sv
// ============================================================================
// ysyx_25030085_idu
// RV32I/RV64I decode stage: one-deep registered bundle, halts on ebreak/illegal.
// Optional macro YSYX_25030085_RVE_EN: register indices >= 16 are illegal.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_25030085_idu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  ysyx_25030085_idu_if.master   bus,
  output logic                  halted,
  output logic [CNT_W-1:0]      dec_cnt
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SLL  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h2;
  localparam logic [3:0] ALU_SLTU = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SRA  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_OR   = 4'h7;
  localparam logic [3:0] ALU_AND  = 4'h8;
  localparam logic [3:0] ALU_PCI  = 4'h9;
  localparam logic [3:0] ALU_SUB  = 4'hA;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;
  localparam logic [1:0] WB_IMM   = 2'b11;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;

  typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_t;

  typedef struct packed {
    logic            mem_wen;
    logic            mem_ren;
    logic [1:0]      mem_size;
    logic            mem_uns;
    logic [1:0]      wb_sel;
    logic            reg_wen;
    logic            branch;
    logic [2:0]      br_func;
    logic [1:0]      jump;
    logic            alu_src;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic            ebreak;
    logic            illegal;
  } bundle_t;

  state_t          state_q, state_d;
  logic            valid_q, valid_d;
  bundle_t         bundle_q, bundle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  bundle_t         dec;
  logic            bad;
  logic            in_rdy;
  logic            in_fire;
  logic            out_fire;

  logic [31:0]     inst;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            shamt_ok;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign inst = bus.in_inst;
  assign opc  = inst[6:0];
  assign f3   = inst[14:12];
  assign f7   = inst[31:25];

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  // RV64 shift immediates own bit 25 as shamt[5]; RV32 reserves it
  assign shamt_ok = !inst[31] && (inst[29:26] == 4'b0000) && ((XLEN == 64) || !inst[25]);

  function automatic logic [3:0] base_alu(input logic [2:0] fn);
    case (fn)
      3'b000:  base_alu = ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec    = '0;
    bad    = 1'b0;
    dec.pc = bus.in_pc;
    case (opc)
      OPC_OPIMM: begin
        dec.reg_wen = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm     = imm_i;
        dec.rs1     = inst[19:15];
        dec.rd      = inst[11:7];
        dec.wb_sel  = WB_ALU;
        dec.alu_op  = base_alu(f3);
        if (f3 == 3'b001) begin
          bad = inst[30] || !shamt_ok;
        end else if (f3 == 3'b101) begin
          dec.alu_op = inst[30] ? ALU_SRA : ALU_SRL;
          bad        = !shamt_ok;
        end
      end
      OPC_OP: begin
        dec.reg_wen = 1'b1;
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.rd      = inst[11:7];
        dec.wb_sel  = WB_ALU;
        if (f7 == 7'b0000000) begin
          dec.alu_op = base_alu(f3);
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.alu_op = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          dec.alu_op = ALU_SRA;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec.reg_wen  = 1'b1;
        dec.mem_ren  = 1'b1;
        dec.wb_sel   = WB_MEM;
        dec.alu_src  = 1'b1;
        dec.alu_op   = ALU_ADD;
        dec.imm      = imm_i;
        dec.rs1      = inst[19:15];
        dec.rd       = inst[11:7];
        dec.mem_size = f3[1:0];
        dec.mem_uns  = f3[2];
        bad = (f3 == 3'b111) || ((XLEN == 32) && (f3 == 3'b011 || f3 == 3'b110));
      end
      OPC_STORE: begin
        dec.mem_wen  = 1'b1;
        dec.alu_src  = 1'b1;
        dec.alu_op   = ALU_ADD;
        dec.imm      = imm_s;
        dec.rs1      = inst[19:15];
        dec.rs2      = inst[24:20];
        dec.mem_size = f3[1:0];
        bad = f3[2] || ((XLEN == 32) && (f3 == 3'b011));
      end
      OPC_BRANCH: begin
        dec.branch  = 1'b1;
        dec.br_func = f3;
        dec.imm     = imm_b;
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        bad = (f3[2:1] == 2'b01);
      end
      OPC_JAL: begin
        dec.reg_wen = 1'b1;
        dec.jump    = JMP_JAL;
        dec.wb_sel  = WB_PC4;
        dec.alu_src = 1'b1;
        dec.alu_op  = ALU_PCI;
        dec.imm     = imm_j;
        dec.rd      = inst[11:7];
      end
      OPC_JALR: begin
        dec.reg_wen = 1'b1;
        dec.jump    = JMP_JALR;
        dec.wb_sel  = WB_PC4;
        dec.alu_src = 1'b1;
        dec.alu_op  = ALU_ADD;
        dec.imm     = imm_i;
        dec.rs1     = inst[19:15];
        dec.rd      = inst[11:7];
        bad = (f3 != 3'b000);
      end
      OPC_LUI: begin
        dec.reg_wen = 1'b1;
        dec.wb_sel  = WB_IMM;
        dec.alu_src = 1'b1;
        dec.imm     = imm_u;
        dec.rd      = inst[11:7];
      end
      OPC_AUIPC: begin
        dec.reg_wen = 1'b1;
        dec.wb_sel  = WB_ALU;
        dec.alu_src = 1'b1;
        dec.alu_op  = ALU_PCI;
        dec.imm     = imm_u;
        dec.rd      = inst[11:7];
      end
      OPC_SYSTEM: begin
        if (inst == INST_EBREAK) dec.ebreak = 1'b1;
        else                     bad        = 1'b1;
      end
      default: bad = 1'b1;
    endcase
`ifdef YSYX_25030085_RVE_EN
    // unused index fields are already zero, so only live indices can trip this
    if (dec.rs1[4] || dec.rs2[4] || dec.rd[4]) bad = 1'b1;
`endif
    if (bad) begin
      dec         = '0;
      dec.pc      = bus.in_pc;
      dec.illegal = 1'b1;
    end
  end

  assign in_rdy   = (state_q == RUN) && (!valid_q || bus.out_ready);
  assign in_fire  = bus.in_valid && in_rdy;
  assign out_fire = valid_q && bus.out_ready;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    bundle_d = bundle_q;
    cnt_d    = cnt_q;
    if (out_fire) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q + CNT_W'(1);
    end
    if (in_fire) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end
    case (state_q)
      RUN:     if (in_fire && (dec.ebreak || dec.illegal)) state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      valid_q  <= 1'b0;
      bundle_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      cnt_q    <= cnt_d;
    end
  end

  assign halted        = (state_q == HALT);
  assign dec_cnt       = cnt_q;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = valid_q;
  assign bus.mem_wen   = bundle_q.mem_wen;
  assign bus.mem_ren   = bundle_q.mem_ren;
  assign bus.mem_size  = bundle_q.mem_size;
  assign bus.mem_uns   = bundle_q.mem_uns;
  assign bus.wb_sel    = bundle_q.wb_sel;
  assign bus.reg_wen   = bundle_q.reg_wen;
  assign bus.branch    = bundle_q.branch;
  assign bus.br_func   = bundle_q.br_func;
  assign bus.jump      = bundle_q.jump;
  assign bus.alu_src   = bundle_q.alu_src;
  assign bus.alu_op    = bundle_q.alu_op;
  assign bus.imm       = bundle_q.imm;
  assign bus.rs1       = bundle_q.rs1;
  assign bus.rs2       = bundle_q.rs2;
  assign bus.rd        = bundle_q.rd;
  assign bus.out_pc    = bundle_q.pc;
  assign bus.ebreak    = bundle_q.ebreak;
  assign bus.illegal   = bundle_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25030085_idu.sv
// ============================================================================
// tb_ysyx_25030085_idu
// Directed scoreboard bench for the decode stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_25030085_idu;
  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
`ifdef YSYX_25030085_RVE_EN
  localparam bit RVE = 1'b1;
`else
  localparam bit RVE = 1'b0;
`endif

  typedef struct packed {
    logic            mem_wen;
    logic            mem_ren;
    logic [1:0]      mem_size;
    logic            mem_uns;
    logic [1:0]      wb_sel;
    logic            reg_wen;
    logic            branch;
    logic [2:0]      br_func;
    logic [1:0]      jump;
    logic            alu_src;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic            ebreak;
    logic            illegal;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             halted;
  logic [CNT_W-1:0] dec_cnt;

  ysyx_25030085_idu_if #(.XLEN(XLEN)) ifc ();

  ysyx_25030085_idu #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifc),
    .halted  (halted),
    .dec_cnt (dec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              checks   = 0;
  int              failures = 0;
  exp_t            sb[$];
  exp_t            nxt_exp;
  exp_t            e;
  logic            in_fire_seen;
  logic            out_fire_seen;
  logic [XLEN-1:0] pc_cnt;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.mem_wen  = ifc.mem_wen;
    o.mem_ren  = ifc.mem_ren;
    o.mem_size = ifc.mem_size;
    o.mem_uns  = ifc.mem_uns;
    o.wb_sel   = ifc.wb_sel;
    o.reg_wen  = ifc.reg_wen;
    o.branch   = ifc.branch;
    o.br_func  = ifc.br_func;
    o.jump     = ifc.jump;
    o.alu_src  = ifc.alu_src;
    o.alu_op   = ifc.alu_op;
    o.imm      = ifc.imm;
    o.rs1      = ifc.rs1;
    o.rs2      = ifc.rs2;
    o.rd       = ifc.rd;
    o.pc       = ifc.out_pc;
    o.ebreak   = ifc.ebreak;
    o.illegal  = ifc.illegal;
    return o;
  endfunction

  // Called at a falling edge; samples the handshake just before the next rising edge.
  task automatic step();
    #1;
    in_fire_seen  = ifc.in_valid && ifc.in_ready;
    out_fire_seen = ifc.out_valid && ifc.out_ready;
    if (out_fire_seen) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL sb_underflow observed=%0d expected=nonzero", sb.size());
      end
      if (sb.size() > 0) chk("bundle", 256'(observed()), 256'(sb.pop_front()));
    end
    if (in_fire_seen) sb.push_back(nxt_exp);
    @(negedge clk);
  endtask

  task automatic present(input logic [31:0] inst, input exp_t ex);
    ifc.in_valid = 1'b1;
    ifc.in_inst  = inst;
    ifc.in_pc    = pc_cnt;
    nxt_exp      = ex;
    nxt_exp.pc   = pc_cnt;
  endtask

  task automatic send(input logic [31:0] inst, input exp_t ex);
    int n;
    present(inst, ex);
    n = 0;
    do begin
      step();
      n++;
    end while (!in_fire_seen && n < 20);
    chk("accept_timeout", 256'(in_fire_seen), 256'(1));
    pc_cnt       = pc_cnt + XLEN'(4);
    ifc.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    rst_n         = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
  endtask

  function automatic exp_t e_addi(input logic [4:0] rd, input logic [XLEN-1:0] imm);
    exp_t x;
    x         = '0;
    x.reg_wen = 1'b1;
    x.alu_src = 1'b1;
    x.imm     = imm;
    x.rd      = rd;
    return x;
  endfunction

  initial begin
    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_inst   = '0;
    ifc.in_pc     = '0;
    ifc.out_ready = 1'b0;
    pc_cnt        = XLEN'(32'h8000_0000);
    nxt_exp       = '0;

    // reset state
    #1;
    chk("rst_out_valid", 256'(ifc.out_valid), 256'(0));
    chk("rst_halted", 256'(halted), 256'(0));
    chk("rst_dec_cnt", 256'(dec_cnt), 256'(0));
    chk("rst_bundle", 256'(observed()), 256'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // full-throughput stream, first accepted on the first edge after reset
    ifc.out_ready = 1'b1;
    send(32'h0050_0093, e_addi(5'd1, XLEN'(5)));
    chk("addi_out_valid", 256'(ifc.out_valid), 256'(1));
    chk("addi_imm", 256'(ifc.imm), 256'(5));
    e = '0; e.reg_wen = 1'b1; e.alu_op = 4'hA; e.rs1 = 5'd1; e.rs2 = 5'd2; e.rd = 5'd3;
    send(32'h4020_81B3, e);
    e = '0; e.reg_wen = 1'b1; e.wb_sel = 2'b11; e.alu_src = 1'b1;
    e.imm = XLEN'(32'sh8000_0000); e.rd = 5'd5;
    send(32'h8000_02B7, e);
    e = '0; e.reg_wen = 1'b1; e.mem_ren = 1'b1; e.mem_uns = 1'b1; e.wb_sel = 2'b01;
    e.alu_src = 1'b1; e.imm = XLEN'(3); e.rs1 = 5'd1; e.rd = 5'd4;
    send(32'h0030_C203, e);
    step();
    step();
    chk("stream_dec_cnt", 256'(dec_cnt), 256'(4));

    // back-to-back with a 3-cycle EXU stall
    do_reset();
    e = '0; e.reg_wen = 1'b1; e.mem_ren = 1'b1; e.mem_size = 2'b10; e.wb_sel = 2'b01;
    e.alu_src = 1'b1; e.imm = XLEN'(-1); e.rs1 = 5'd1; e.rd = 5'd2;
    send(32'hFFF0_A103, e);
    e = '0; e.mem_wen = 1'b1; e.mem_size = 2'b10; e.alu_src = 1'b1; e.imm = XLEN'(8);
    e.rs1 = 5'd1; e.rs2 = 5'd2;
    present(32'h0020_A423, e);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", 256'(ifc.in_ready), 256'(0));
      chk("stall_out_valid", 256'(ifc.out_valid), 256'(1));
      if (sb.size() > 0) chk("stall_hold", 256'(observed()), 256'(sb[0]));
      step();
    end
    ifc.out_ready = 1'b1;
    send(32'h0020_A423, e);
    e = '0; e.branch = 1'b1; e.imm = XLEN'(-16); e.rs1 = 5'd1; e.rs2 = 5'd2;
    send(32'hFE20_88E3, e);
    e = '0; e.reg_wen = 1'b1; e.jump = 2'b01; e.wb_sel = 2'b10; e.alu_src = 1'b1;
    e.alu_op = 4'h9; e.imm = XLEN'(-8); e.rd = 5'd1;
    send(32'hFF9F_F0EF, e);
    step();
    step();
    chk("stall_dec_cnt", 256'(dec_cnt), 256'(4));
    chk("stall_sb_empty", 256'(sb.size()), 256'(0));

    // ebreak halts the stage, bundle still delivered
    do_reset();
    ifc.out_ready = 1'b1;
    e = '0; e.ebreak = 1'b1;
    send(32'h0010_0073, e);
    chk("ebreak_halted", 256'(halted), 256'(1));
    present(32'h0050_0093, e_addi(5'd1, XLEN'(5)));
    for (int i = 0; i < 10; i++) begin
      chk("halt_in_ready", 256'(ifc.in_ready), 256'(0));
      step();
    end
    ifc.in_valid = 1'b0;
    chk("halt_sb_empty", 256'(sb.size()), 256'(0));

    // illegal instruction, then reset while stalled
    do_reset();
    e = '0; e.illegal = 1'b1;
    send(32'hFFFF_FFFF, e);
    chk("illegal_halted", 256'(halted), 256'(1));
    step();
    step();
    if (sb.size() > 0) chk("illegal_hold", 256'(observed()), 256'(sb[0]));
    rst_n = 1'b0;
    #1;
    chk("midstall_rst_valid", 256'(ifc.out_valid), 256'(0));
    chk("midstall_rst_halted", 256'(halted), 256'(0));
    chk("midstall_rst_bundle", 256'(observed()), 256'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_in_ready", 256'(ifc.in_ready), 256'(1));
    ifc.out_ready = 1'b1;
    send(32'h0050_0093, e_addi(5'd1, XLEN'(5)));
    step();
    step();
    chk("post_rst_dec_cnt", 256'(dec_cnt), 256'(1));

    // addi x16: legal only for the full register file
    if (RVE) begin
      e = '0; e.illegal = 1'b1;
    end else begin
      e = e_addi(5'd16, XLEN'(16));
    end
    send(32'h0100_0813, e);
    step();
    step();
    chk("x16_halted", 256'(halted), 256'(RVE));
    chk("final_sb_empty", 256'(sb.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
